// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: RV32 opcodes the
// predecoder recognises, FSM state encodings and a word-alignment helper.
package inst_fetch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] INST_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/inst_fetch_predecode.sv
// Purely combinational predecode of a held instruction word: classifies
// conditional branches and JAL and extracts their sign-extended immediates.
module inst_predecode
    import inst_fetch_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_branch,
    output logic        is_jal,
    output logic [31:0] b_imm,
    output logic [31:0] j_imm
);

    logic [6:0] opcode;

    assign opcode    = inst[6:0];
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);

    // B-type: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7]
    assign b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

    // J-type: imm[20|10:1|11|19:12] in [31:12]
    assign j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch: requests a word from the icache,
// holds it for the decoder, and steers the next PC from branch/JAL predecode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_inst,

    output logic        bp_branch,
    output logic [31:0] bp_pc,
    output logic [31:0] bp_imm,
    input  logic        need_branch,
    input  logic [31:0] branch_addr,

    input  logic        predict_fail,
    input  logic [31:0] fail_addr,

    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         drop;
    logic         ic_req_q;

    logic         is_branch;
    logic         is_jal;
    logic [31:0]  b_imm;
    logic [31:0]  j_imm;

    logic         handoff;
    logic [31:0]  next_pc;

    inst_predecode u_predecode (
        .inst      (out_inst),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .b_imm     (b_imm),
        .j_imm     (j_imm)
    );

    // A flush wins over the decoder accepting the word in the same cycle.
    assign handoff = (state == S_HOLD) && out_ready && rdy_in && !predict_fail;

    // The predictor answers need_branch combinationally, so this cannot be registered.
    assign bp_branch = handoff && is_branch;
    assign bp_pc     = out_pc;
    assign bp_imm    = b_imm;

    // The request pulse is registered; a stall masks it without consuming it.
    assign ic_req  = ic_req_q && rdy_in;
    assign ic_addr = pc;

    always_comb begin
        // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
        next_pc = out_pc + INST_STEP;
        if (is_branch && need_branch) begin
            next_pc = branch_addr;
        end else if (is_jal) begin
            next_pc = out_pc + j_imm;
        end
        next_pc = word_align(next_pc);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= S_IDLE;
            pc        <= word_align(RESET_PC);
            drop      <= 1'b0;
            ic_req_q  <= 1'b0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
        end else if (rdy_in) begin
            ic_req_q <= 1'b0;
            if (predict_fail) begin
                pc <= word_align(fail_addr);
                unique case (state)
                    S_IDLE: state <= S_IDLE;
                    S_WAIT: begin
                        // A response landing with the flush belongs to the old path.
                        if (ic_valid) begin
                            drop  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else begin
                unique case (state)
                    S_IDLE: begin
                        ic_req_q <= 1'b1;
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (ic_valid) begin
                            if (drop) begin
                                drop  <= 1'b0;
                                state <= S_IDLE;
                            end else begin
                                out_valid <= 1'b1;
                                out_inst  <= ic_inst;
                                out_pc    <= pc;
                                state     <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            pc        <= next_pc;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: reset, sequential fetch,
// branch/JAL steering, flushes in each state, stalls and PC wrap-around.
module tb_inst_fetch;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BEQ   = 32'hFE00_0CE3;  // beq, imm = -8
    localparam logic [31:0] JAL16 = 32'h0100_006F;  // jal x0, +16
    localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_inst;
    logic        bp_branch;
    logic [31:0] bp_pc;
    logic [31:0] bp_imm;
    logic        need_branch;
    logic [31:0] branch_addr;
    logic        predict_fail;
    logic [31:0] fail_addr;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .ic_req       (ic_req),
        .ic_addr      (ic_addr),
        .ic_valid     (ic_valid),
        .ic_inst      (ic_inst),
        .bp_branch    (bp_branch),
        .bp_pc        (bp_pc),
        .bp_imm       (bp_imm),
        .need_branch  (need_branch),
        .branch_addr  (branch_addr),
        .predict_fail (predict_fail),
        .fail_addr    (fail_addr),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_ready    (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Bounded wait for the next request, then check its address.
    task automatic wait_req(input logic [31:0] exp_addr, input string tag);
        int n = 0;
        while (ic_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, {31'b0, ic_req}, 32'd1);
        check({tag, "_addr"}, ic_addr, exp_addr);
    endtask

    // Called in the cycle ic_req is high; answers one cycle later and
    // checks the word lands in the hold registers.
    task automatic deliver(input logic [31:0] word, input logic [31:0] exp_pc, input string tag);
        tick();
        ic_valid = 1'b1;
        ic_inst  = word;
        tick();
        ic_valid = 1'b0;
        #1;
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_inst"}, out_inst, word);
        check({tag, "_pc"}, out_pc, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; ic_valid = 1'b0; ic_inst = '0;
        need_branch = 1'b0; branch_addr = '0; predict_fail = 1'b0;
        fail_addr = '0; out_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_ic_req",    {31'b0, ic_req},    32'd0);
        check("rst_ic_addr",   ic_addr,            32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_inst",  out_inst,           32'h0);
        check("rst_out_pc",    out_pc,             32'h0);
        check("rst_bp_branch", {31'b0, bp_branch}, 32'd0);
        rst_in = 1'b1;
        #1;
        check("rel_no_req", {31'b0, ic_req}, 32'd0);

        // First request on the first enabled edge; plain fetch and handoff
        tick();
        check("first_req",  {31'b0, ic_req}, 32'd1);
        check("first_addr", ic_addr,         32'h0);
        tick();
        check("req_pulse_end", {31'b0, ic_req}, 32'd0);
        tick();
        ic_valid = 1'b1; ic_inst = NOP; out_ready = 1'b1;
        tick();
        ic_valid = 1'b0;
        #1;
        check("nop_valid",  {31'b0, out_valid}, 32'd1);
        check("nop_inst",   out_inst,           NOP);
        check("nop_pc",     out_pc,             32'h0);
        check("nop_no_bp",  {31'b0, bp_branch}, 32'd0);
        tick();
        out_ready = 1'b0;
        check("nop_out_low", {31'b0, out_valid}, 32'd0);
        wait_req(32'h4, "nop_next");

        // Flush coincident with a HOLD handoff of a branch
        deliver(BEQ, 32'h4, "hflush");
        out_ready = 1'b1; predict_fail = 1'b1; fail_addr = 32'h100;
        #1;
        check("hflush_no_bp", {31'b0, bp_branch}, 32'd0);
        tick();
        predict_fail = 1'b0; out_ready = 1'b0;
        #1;
        check("hflush_out_low", {31'b0, out_valid}, 32'd0);
        wait_req(32'h100, "hflush_next");

        // Branch not taken; stray ic_valid in HOLD is ignored
        deliver(BEQ, 32'h100, "bnt");
        ic_valid = 1'b1; ic_inst = JUNK;
        tick();
        ic_valid = 1'b0;
        #1;
        check("stray_inst",  out_inst,           BEQ);
        check("stray_valid", {31'b0, out_valid}, 32'd1);
        check("bnt_idle_bp", {31'b0, bp_branch}, 32'd0);
        check("bnt_imm",     bp_imm,             32'hFFFF_FFF8);
        out_ready = 1'b1; need_branch = 1'b0;
        #1;
        check("bnt_bp", {31'b0, bp_branch}, 32'd1);
        tick();
        out_ready = 1'b0;
        #1;
        check("bnt_bp_once", {31'b0, bp_branch}, 32'd0);
        wait_req(32'h104, "bnt_next");

        // Flush in IDLE suppresses the request and restarts at fail_addr
        deliver(NOP, 32'h104, "iflush");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; predict_fail = 1'b1; fail_addr = 32'h100;
        tick();
        predict_fail = 1'b0;
        #1;
        check("iflush_no_req", {31'b0, ic_req}, 32'd0);
        tick();
        check("iflush_req",  {31'b0, ic_req}, 32'd1);
        check("iflush_addr", ic_addr,         32'h100);

        // Branch taken
        deliver(BEQ, 32'h100, "btk");
        out_ready = 1'b1; need_branch = 1'b1; branch_addr = 32'hF8;
        #1;
        check("btk_bp",     {31'b0, bp_branch}, 32'd1);
        check("btk_bp_imm", bp_imm,             32'hFFFF_FFF8);
        check("btk_bp_pc",  bp_pc,              32'h100);
        tick();
        out_ready = 1'b0; need_branch = 1'b0;
        #1;
        check("btk_bp_once", {31'b0, bp_branch}, 32'd0);
        wait_req(32'hF8, "btk_next");

        // Flush in WAIT, late response is dropped
        tick();
        predict_fail = 1'b1; fail_addr = 32'h200;
        tick();
        predict_fail = 1'b0;
        tick();
        tick();
        ic_valid = 1'b1; ic_inst = NOP;
        tick();
        ic_valid = 1'b0;
        #1;
        check("wdrop_out_low", {31'b0, out_valid}, 32'd0);
        check("wdrop_no_req",  {31'b0, ic_req},    32'd0);
        wait_req(32'h200, "wdrop_next");

        // Flush and response in the same WAIT cycle
        predict_fail = 1'b1; fail_addr = 32'h300; ic_valid = 1'b1; ic_inst = NOP;
        tick();
        predict_fail = 1'b0; ic_valid = 1'b0;
        #1;
        check("wsame_out_low", {31'b0, out_valid}, 32'd0);
        wait_req(32'h300, "wsame_next");

        // Stall in HOLD with out_ready high, then JAL handoff
        deliver(JAL16, 32'h300, "stall");
        out_ready = 1'b1; rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_no_req", {31'b0, ic_req}, 32'd0);
        end
        rdy_in = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("stall_handoff", {31'b0, out_valid}, 32'd0);
        wait_req(32'h310, "jal_next");

        // Reset mid-fetch; stray response during reset is ignored
        rst_in = 1'b0;
        #1;
        check("mid_rst_req",  {31'b0, ic_req}, 32'd0);
        check("mid_rst_addr", ic_addr,         32'h0);
        tick();
        ic_valid = 1'b1; ic_inst = JUNK;
        tick();
        ic_valid = 1'b0;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        rst_in = 1'b1;
        wait_req(32'h0, "mid_rst_next");

        // Unaligned restart target and 32-bit PC wrap-around
        deliver(NOP, 32'h0, "wrap0");
        out_ready = 1'b1; predict_fail = 1'b1; fail_addr = 32'hFFFF_FFFE;
        tick();
        predict_fail = 1'b0; out_ready = 1'b0;
        wait_req(32'hFFFF_FFFC, "align");
        deliver(NOP, 32'hFFFF_FFFC, "wrap1");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_req(32'h0, "wrap_next");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-002 SHALL have port clk_in, input, 1: the single clock; all state is on the rising edge.
REQ-003 SHALL have port rst_in, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port rdy_in, input, 1: global enable; low freezes all state.
REQ-005 SHALL have port ic_req, output, 1: fetch request to the icache, one-cycle pulse.
REQ-006 SHALL have port ic_addr, output, 32: fetch address, bits [1:0] always 2'b00.
REQ-007 SHALL have port ic_valid, input, 1: icache response valid.
REQ-008 SHALL have port ic_inst, input, 32: icache response word.
REQ-009 SHALL have port bp_branch, output, 1: conditional-branch handoff pulse to the branch predictor.
REQ-010 SHALL have port bp_pc, output, 32: PC of the held instruction.
REQ-011 SHALL have port bp_imm, output, 32: sign-extended B-type immediate.
REQ-012 SHALL have port need_branch, input, 1: predictor taken decision, combinational from bp_branch.
REQ-013 SHALL have port branch_addr, input, 32: predicted target.
REQ-014 SHALL have port predict_fail, input, 1: misprediction flush.
REQ-015 SHALL have port fail_addr, input, 32: restart PC on flush.
REQ-016 SHALL have port out_valid, output, 1: held instruction valid toward the decoder.
REQ-017 SHALL have port out_inst, output, 32: held instruction word.
REQ-018 SHALL have port out_pc, output, 32: held instruction PC.
REQ-019 SHALL have port out_ready, input, 1: decoder accepts the held instruction.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT and HOLD.
REQ-021 IDLE SHALL assert ic_req with ic_addr=pc for one cycle and then go to WAIT.
REQ-022 WAIT, on ic_valid with drop=0, SHALL latch ic_inst and pc into hold registers and go to HOLD; out_valid is high the next cycle.
REQ-023 HOLD SHALL drive out_valid=1; handoff occurs when out_ready=1, and the FSM then goes to IDLE.
REQ-024 Predecode: opcode 7'b1100011 is a branch, imm={{20{i[31]}},i[7],i[30:25],i[11:8],1'b0}; opcode 7'b1101111 is JAL, J-imm sign-extended.
REQ-025 bp_branch SHALL be high only in a handoff cycle of a branch instruction with predict_fail=0, and exactly once per such instruction.
REQ-026 Next pc at handoff:
 - branch: need_branch ? branch_addr : pc+4
 - JAL: pc+J-imm
 - otherwise: pc+4
 - 32-bit wrap-around; the result SHALL have bits [1:0] cleared.
REQ-027 predict_fail SHALL take priority over every other event in the same cycle and set pc<=fail_addr.
 - IDLE: suppress ic_req that cycle; stay in IDLE.
 - HOLD: discard the held instruction; out_valid=0 next cycle; no handoff; go to IDLE.
 - WAIT: set drop=1 and stay in WAIT.
REQ-028 WAIT with drop=1 and ic_valid SHALL discard the word, clear drop and go to IDLE.
REQ-029 ic_valid coincident with predict_fail in WAIT SHALL be discarded; the FSM goes to IDLE with drop=0.
REQ-030 rdy_in=0 SHALL:
 - hold all registers;
 - force ic_req=0 and bp_branch=0;
 - keep out_valid at its registered value;
 - perform no handoff.
REQ-031 ic_valid outside WAIT SHALL be ignored.
REQ-032 At most one fetch SHALL be outstanding at any time.

Reset
REQ-033 While rst_in=0, outputs SHALL be: pc=RESET_PC, state=IDLE, drop=0, ic_req=0, out_valid=0, out_inst=0, out_pc=0, bp_branch=0.
REQ-034 The first ic_req SHALL occur on the first rising edge with rst_in=1 and rdy_in=1.
REQ-035 Reset asserted mid-operation SHALL abandon any outstanding fetch; a later stray ic_valid is ignored per REQ-031.

Structure
REQ-036 The shared macros/package SHALL hold OPC_BRANCH, OPC_JAL and the FSM state encodings.
REQ-037 The combinational sub-module inst_predecode (inst -> is_branch, is_jal, b_imm, j_imm) SHALL hold the predecode logic; everything else is in inst_fetch.

Verification
REQ-038 Reset, then ic_valid with 32'h00000013 after 2 cycles, out_ready=1 -> ic_addr 0, out_pc 0, next ic_addr 4, bp_branch never high.
REQ-039 pc=0x100, inst beq imm=-8 (32'hFE000CE3), need_branch=1, branch_addr=0xF8 -> one-cycle bp_branch, bp_imm=32'hFFFFFFF8, next ic_addr=0xF8.
REQ-040 Same branch, need_branch=0 -> next ic_addr=0x104.
REQ-041 predict_fail with fail_addr=0x200 in WAIT, ic_valid 3 cycles later -> word dropped, out_valid stays 0, next ic_addr=0x200.
REQ-042 predict_fail in the same cycle as a HOLD handoff with out_ready=1 -> no bp_branch, out_valid falls, next ic_addr=fail_addr.
REQ-043 rdy_in=0 for 5 cycles in HOLD with out_ready=1 -> no handoff, out_valid steady; handoff on the first cycle rdy_in returns high.
